// File: rtl/mem_bus_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : mem_bus_arbiter
// Purpose  : Round-robin arbiter sharing one memory port between IFU (m0) and
//            LSU (m1), with a request/response FSM and a response timeout.
// Revision : 1.0 - initial release
// ============================================================================
module mem_bus_arbiter #(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 255
) (
    input  logic              clk,
    input  logic              rst,

    input  logic              m0_req_valid,
    input  logic [ADDR_W-1:0] m0_req_addr,
    output logic              m0_req_ready,
    output logic              m0_resp_valid,
    output logic [DATA_W-1:0] m0_resp_data,
    output logic              m0_resp_err,

    input  logic              m1_req_valid,
    input  logic [ADDR_W-1:0] m1_req_addr,
    input  logic              m1_req_wen,
    input  logic [DATA_W-1:0] m1_req_wdata,
    input  logic [3:0]        m1_req_wmask,
    output logic              m1_req_ready,
    output logic              m1_resp_valid,
    output logic [DATA_W-1:0] m1_resp_data,
    output logic              m1_resp_err,

    output logic              s_req_valid,
    input  logic              s_req_ready,
    output logic [ADDR_W-1:0] s_req_addr,
    output logic              s_req_wen,
    output logic [DATA_W-1:0] s_req_wdata,
    output logic [3:0]        s_req_wmask,
    input  logic              s_resp_valid,
    input  logic [DATA_W-1:0] s_resp_data,
    input  logic              s_resp_err,

    output logic              busy,
    output logic [1:0]        grant
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    localparam logic [15:0] c_timeout = 16'(TIMEOUT);

    state_t            r_state;
    logic              r_owner;       // 0 = IFU, 1 = LSU
    logic              r_last_grant;
    logic [ADDR_W-1:0] r_addr;
    logic              r_wen;
    logic [DATA_W-1:0] r_wdata;
    logic [3:0]        r_wmask;
    logic [15:0]       r_cnt;

    logic              w_live;
    logic              w_busy;
    logic              w_in_req;
    logic              w_in_resp;
    logic              w_pick_lsu;
    logic              w_accept;
    logic              w_resp_fire;
    logic              w_resp_err;
    logic [DATA_W-1:0] w_resp_data;

    // Handshake outputs must react in the same cycle as the slave, so they are
    // decoded from registered state and gated off while reset is asserted.
    assign w_live      = ~rst;
    assign w_busy      = w_live & (r_state != ST_IDLE);
    assign w_in_req    = w_live & (r_state == ST_REQ);
    assign w_in_resp   = w_live & (r_state == ST_RESP);

    // On a tie the master that did not win last time is chosen.
    assign w_pick_lsu  = m1_req_valid & (~m0_req_valid | ~r_last_grant);

    assign w_accept    = w_in_req & s_req_ready;
    assign w_resp_fire = w_in_resp & (s_resp_valid | (r_cnt == c_timeout));
    assign w_resp_err  = s_resp_valid ? s_resp_err : 1'b1;
    assign w_resp_data = (s_resp_valid & ~r_wen) ? s_resp_data : '0;

    assign s_req_valid   = w_in_req;
    assign s_req_addr    = w_in_req ? r_addr  : '0;
    assign s_req_wen     = w_in_req & r_wen;
    assign s_req_wdata   = w_in_req ? r_wdata : '0;
    assign s_req_wmask   = w_in_req ? r_wmask : 4'b0000;

    assign m0_req_ready  = w_accept & ~r_owner;
    assign m1_req_ready  = w_accept &  r_owner;
    assign m0_resp_valid = w_resp_fire & ~r_owner;
    assign m1_resp_valid = w_resp_fire &  r_owner;
    assign m0_resp_err   = m0_resp_valid & w_resp_err;
    assign m1_resp_err   = m1_resp_valid & w_resp_err;
    assign m0_resp_data  = m0_resp_valid ? w_resp_data : '0;
    assign m1_resp_data  = m1_resp_valid ? w_resp_data : '0;

    assign busy  = w_busy;
    assign grant = {w_busy & r_owner, w_busy & ~r_owner};

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= ST_IDLE;
            r_owner      <= 1'b0;
            r_last_grant <= 1'b1;
            r_addr       <= '0;
            r_wen        <= 1'b0;
            r_wdata      <= '0;
            r_wmask      <= 4'b0000;
            r_cnt        <= 16'd0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (m0_req_valid | m1_req_valid) begin
                        r_owner      <= w_pick_lsu;
                        r_last_grant <= w_pick_lsu;
                        r_state      <= ST_REQ;
                        if (w_pick_lsu) begin
                            r_addr  <= m1_req_addr;
                            r_wen   <= m1_req_wen;
                            r_wdata <= m1_req_wdata;
                            r_wmask <= m1_req_wmask;
                        end else begin
                            r_addr  <= m0_req_addr;
                            r_wen   <= 1'b0;
                            r_wdata <= '0;
                            r_wmask <= 4'b0000;
                        end
                    end
                end
                ST_REQ: begin
                    if (s_req_ready) begin
                        r_state <= ST_RESP;
                        r_cnt   <= 16'd0;
                    end
                end
                ST_RESP: begin
                    r_cnt <= r_cnt + 16'd1;
                    if (s_resp_valid || (r_cnt == c_timeout)) begin
                        r_state <= ST_IDLE;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_mem_bus_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_mem_bus_arbiter
// Purpose  : Directed + randomized transaction bench for mem_bus_arbiter.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mem_bus_arbiter;

    localparam int TO = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        m0_req_valid, m0_req_ready, m0_resp_valid, m0_resp_err;
    logic [31:0] m0_req_addr, m0_resp_data;
    logic        m1_req_valid, m1_req_wen, m1_req_ready, m1_resp_valid, m1_resp_err;
    logic [31:0] m1_req_addr, m1_req_wdata, m1_resp_data;
    logic [3:0]  m1_req_wmask;
    logic        s_req_valid, s_req_ready, s_req_wen, s_resp_valid, s_resp_err;
    logic [31:0] s_req_addr, s_req_wdata, s_resp_data;
    logic [3:0]  s_req_wmask;
    logic        busy;
    logic [1:0]  grant;

    always #5 clk = ~clk;

    mem_bus_arbiter #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(TO)) dut (
        .clk(clk), .rst(rst),
        .m0_req_valid(m0_req_valid), .m0_req_addr(m0_req_addr),
        .m0_req_ready(m0_req_ready), .m0_resp_valid(m0_resp_valid),
        .m0_resp_data(m0_resp_data), .m0_resp_err(m0_resp_err),
        .m1_req_valid(m1_req_valid), .m1_req_addr(m1_req_addr),
        .m1_req_wen(m1_req_wen), .m1_req_wdata(m1_req_wdata),
        .m1_req_wmask(m1_req_wmask), .m1_req_ready(m1_req_ready),
        .m1_resp_valid(m1_resp_valid), .m1_resp_data(m1_resp_data),
        .m1_resp_err(m1_resp_err),
        .s_req_valid(s_req_valid), .s_req_ready(s_req_ready),
        .s_req_addr(s_req_addr), .s_req_wen(s_req_wen),
        .s_req_wdata(s_req_wdata), .s_req_wmask(s_req_wmask),
        .s_resp_valid(s_resp_valid), .s_resp_data(s_resp_data),
        .s_resp_err(s_resp_err),
        .busy(busy), .grant(grant)
    );

    int n_pass = 0;
    int n_chk  = 0;

    // Requester-side model: pending flags and the payload each master holds.
    bit          p0, p1;
    logic [31:0] a0, a1, wd1;
    logic        w1;
    logic [3:0]  mk1;
    int          last_owner;
    bit          force_junk;

    logic [34:0] e_m0, e_m1;
    logic [69:0] e_s;
    logic [2:0]  e_st;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    task automatic sample_check(input string ph);
        @(negedge clk);
        chk({ph, "/m0"}, 128'({m0_req_ready, m0_resp_valid, m0_resp_err, m0_resp_data}), 128'(e_m0));
        chk({ph, "/m1"}, 128'({m1_req_ready, m1_resp_valid, m1_resp_err, m1_resp_data}), 128'(e_m1));
        chk({ph, "/slave"}, 128'({s_req_valid, s_req_addr, s_req_wen, s_req_wdata, s_req_wmask}), 128'(e_s));
        chk({ph, "/status"}, 128'({busy, grant}), 128'(e_st));
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_masters();
        m0_req_valid = p0;
        m0_req_addr  = p0 ? a0 : $urandom;
        m1_req_valid = p1;
        m1_req_addr  = p1 ? a1  : $urandom;
        m1_req_wen   = p1 ? w1  : 1'($urandom);
        m1_req_wdata = p1 ? wd1 : $urandom;
        m1_req_wmask = p1 ? mk1 : 4'($urandom);
    endtask

    // Raise fresh requests on idle masters (never on the one in flight).
    task automatic maybe_new(input int pct, input int own);
        if (!p0 && own != 0 && $urandom_range(99) < pct) begin
            p0 = 1; a0 = $urandom;
        end
        if (!p1 && own != 1 && $urandom_range(99) < pct) begin
            p1 = 1; a1 = $urandom; w1 = 1'($urandom); wd1 = $urandom; mk1 = 4'($urandom);
        end
    endtask

    // One arbitration round from an IDLE cycle. rsp_dly = RESP cycles before
    // the slave answers (>TO means never); rst_at = RESP cycle to reset in.
    task automatic round(input int acc_dly, input int rsp_dly, input int rst_at,
                         input int new_pct, input logic [31:0] sdata, input logic serr);
        int          own;
        logic [69:0] req_fields;
        logic        own_wen;
        logic [34:0] rsp;
        bit          fire;

        step();
        rst = 1'b0;
        maybe_new(new_pct, -1);
        drive_masters();
        s_req_ready  = 1'($urandom);
        s_resp_valid = force_junk | 1'($urandom);
        s_resp_data  = $urandom;
        s_resp_err   = 1'($urandom);
        if (!p0 && !p1)     own = -1;
        else if (p0 && p1)  own = 1 - last_owner;
        else                own = p0 ? 0 : 1;
        e_m0 = '0; e_m1 = '0; e_s = '0; e_st = '0;
        sample_check("idle");
        if (own < 0) return;
        last_owner = own;
        own_wen    = (own == 1) ? w1 : 1'b0;
        req_fields = (own == 0) ? {1'b1, a0, 1'b0, 32'h0, 4'h0} : {1'b1, a1, w1, wd1, mk1};

        for (int i = 0; i <= acc_dly; i++) begin
            step();
            maybe_new(new_pct, own);
            drive_masters();
            s_req_ready  = (i == acc_dly);
            s_resp_valid = (i == acc_dly) ? 1'b0 : 1'($urandom);
            s_resp_data  = $urandom;
            s_resp_err   = 1'($urandom);
            e_s  = req_fields;
            e_st = {1'b1, own == 1, own == 0};
            e_m0 = {(own == 0) && (i == acc_dly), 34'h0};
            e_m1 = {(own == 1) && (i == acc_dly), 34'h0};
            sample_check("req");
        end
        if (own == 0) p0 = 0; else p1 = 0;

        for (int j = 0; j <= TO; j++) begin
            step();
            maybe_new(new_pct, own);
            s_req_ready  = 1'($urandom);
            s_resp_valid = (j == rsp_dly);
            s_resp_data  = (j == rsp_dly) ? sdata : $urandom;
            s_resp_err   = (j == rsp_dly) ? serr  : 1'($urandom);
            if (j == rst_at) begin
                rst = 1'b1;
                p0 = 0; p1 = 0;
                drive_masters();
                last_owner = 1;
                e_m0 = '0; e_m1 = '0; e_s = '0; e_st = '0;
                sample_check("reset-resp");
                return;
            end
            drive_masters();
            fire = (j == rsp_dly) || (j == TO);
            if (j == rsp_dly) rsp = {1'b0, 1'b1, serr, own_wen ? 32'h0 : sdata};
            else              rsp = {1'b0, 1'b1, 1'b1, 32'h0};
            e_s  = '0;
            e_st = {1'b1, own == 1, own == 0};
            e_m0 = (fire && own == 0) ? rsp : '0;
            e_m1 = (fire && own == 1) ? rsp : '0;
            sample_check("resp");
            if (fire) break;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        p0 = 0; p1 = 0; a0 = 0; a1 = 0; w1 = 0; wd1 = 0; mk1 = 0;
        last_owner = 1;
        force_junk = 0;
        drive_masters();
        s_req_ready = 0; s_resp_valid = 0; s_resp_data = 0; s_resp_err = 0;
        step();
        step();
        e_m0 = '0; e_m1 = '0; e_s = '0; e_st = '0;
        sample_check("reset");

        // Tie after reset goes to IFU, then alternation under contention.
        p0 = 1; a0 = 32'h8000_0004;
        p1 = 1; a1 = 32'h8000_1000; w1 = 0; wd1 = 0; mk1 = 4'hF;
        round(0, 0, -1, 0, 32'h1111_0000, 1'b0);
        p0 = 1; a0 = 32'h8000_0008;
        round(0, 1, -1, 0, 32'h2222_0000, 1'b0);
        p1 = 1; a1 = 32'h8000_1004;
        round(1, 0, -1, 0, 32'h3333_0000, 1'b0);
        round(0, 2, -1, 0, 32'h4444_0000, 1'b0);

        // Single IFU read, then trailing idle cycle.
        p0 = 1; a0 = 32'h8000_0000;
        round(0, 1, -1, 0, 32'h0000_0413, 1'b0);
        round(0, 0, -1, 0, 32'h0, 1'b0);

        // LSU write with a 3-cycle stall on accept; data returned as 0.
        p1 = 1; a1 = 32'h8000_2000; w1 = 1; wd1 = 32'hDEAD_BEEF; mk1 = 4'b0011;
        round(3, 0, -1, 0, 32'hCAFE_F00D, 1'b0);

        // Timeout, then idle cycles with a stray late slave response.
        p1 = 1; a1 = 32'h8000_3000; w1 = 0; wd1 = 0; mk1 = 4'hF;
        round(0, 100, -1, 0, 32'h0, 1'b0);
        force_junk = 1;
        round(0, 0, -1, 0, 32'h0, 1'b0);
        round(0, 0, -1, 0, 32'h0, 1'b0);
        force_junk = 0;

        // Slave response coinciding with the timeout wins.
        p0 = 1; a0 = 32'h8000_0010;
        round(0, TO, -1, 0, 32'h5555_AAAA, 1'b0);

        // Slave error on an IFU read.
        p0 = 1; a0 = 32'h8000_0014;
        round(0, 0, -1, 0, 32'h1234_5678, 1'b1);

        // Randomized traffic with contention and arbitrary slave timing.
        for (int k = 0; k < 60; k++) begin
            round($urandom_range(3), $urandom_range(TO + 1), -1, 50, $urandom, 1'($urandom));
        end

        // Reset while in RESP, then a tie goes to IFU again.
        p0 = 0; p1 = 0;
        round(0, 0, -1, 0, 32'h0, 1'b0);
        p1 = 1; a1 = 32'h8000_4000; w1 = 0; wd1 = 0; mk1 = 4'hF;
        round(1, 100, 2, 0, 32'h0, 1'b0);
        round(0, 0, -1, 0, 32'h0, 1'b0);
        p0 = 1; a0 = 32'h8000_0020;
        p1 = 1; a1 = 32'h8000_4004;
        round(0, 0, -1, 0, 32'h6666_0000, 1'b0);
        round(0, 0, -1, 0, 32'h7777_0000, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/mem_bus_arbiter.md
Name: mem_bus_arbiter

Overview:
- Shares one memory port between the instruction-fetch requester (IFU, read-only, master 0) and the load/store requester (LSU, read/write, master 1).
- Sits between the fetch/load-store units and the single memory slave.
- Grants by round-robin, sequences each access through a request/response FSM, and returns an error response if the slave stalls beyond a timeout.

Parameters:
- ADDR_W, 32, address width
- DATA_W, 32, data width
- TIMEOUT, 255, max cycles in RESP before a forced error response (1..65535)

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- m0_req_valid  in  1  IFU request
- m0_req_addr  in  ADDR_W  IFU address
- m0_req_ready  out  1  IFU request accepted (1-cycle pulse)
- m0_resp_valid  out  1  IFU response (1-cycle pulse)
- m0_resp_data  out  DATA_W  IFU read data
- m0_resp_err  out  1  IFU error flag
- m1_req_valid  in  1  LSU request
- m1_req_addr  in  ADDR_W  LSU address
- m1_req_wen  in  1  1=write, 0=read
- m1_req_wdata  in  DATA_W  write data
- m1_req_wmask  in  4  byte strobes
- m1_req_ready  out  1  LSU request accepted (1-cycle pulse)
- m1_resp_valid  out  1  LSU response (1-cycle pulse)
- m1_resp_data  out  DATA_W  LSU read data (0 for writes)
- m1_resp_err  out  1  LSU error flag
- s_req_valid  out  1  slave request
- s_req_ready  in  1  slave accepts request
- s_req_addr  out  ADDR_W  slave address
- s_req_wen  out  1  slave write enable
- s_req_wdata  out  DATA_W  slave write data
- s_req_wmask  out  4  slave strobes
- s_resp_valid  in  1  slave response
- s_resp_data  in  DATA_W  slave read data
- s_resp_err  in  1  slave error
- busy  out  1  FSM not IDLE
- grant  out  2  one-hot current owner, 00 when IDLE

Behaviour:
- Clock and reset: single clock clk. Reset rst is synchronous, active-high.
- Reset state: FSM=IDLE; last_grant=1 (LSU), so the first tie goes to IFU; timeout counter=0.
- Outputs during reset: s_req_valid, s_req_wen, m*_req_ready, m*_resp_valid, m*_resp_err, busy = 0; grant=00; all data/addr outputs = 0.
- Requester rule: a master holds valid and its payload stable until its req_ready pulse.
- Requester rule: at most one outstanding transaction per master.
- IDLE:
  - If any req_valid, register the owner and capture its payload into internal registers. Next state = REQ.
  - Owner selection: the sole requester; if both request, the master not equal to last_grant.
  - last_grant updates on this grant.
  - IFU payload forces wen=0, wmask=0, wdata=0.
- REQ:
  - s_req_valid=1, driven from the captured registers.
  - On s_req_valid & s_req_ready: pulse the owner's req_ready in the same cycle. Next state = RESP; counter cleared.
  - No timeout in REQ.
- RESP:
  - s_req_valid=0. Counter increments each cycle.
  - On s_resp_valid: forward it to the owner in the same cycle (resp_valid=1, resp_data=s_resp_data, resp_err=s_resp_err). Next state = IDLE.
  - If the counter reaches TIMEOUT with no s_resp_valid: owner resp_valid=1, resp_err=1, resp_data=0. Next state = IDLE.
  - If s_resp_valid and timeout coincide, the slave response wins.
  - A late slave response arriving after a timeout is ignored (FSM is IDLE).
- s_resp_valid outside RESP is ignored. The slave must not respond in the same cycle it accepts a request.
- Non-owner master: req_ready and resp_valid stay 0; its request waits.
- Minimum latency: grant to response is 3 cycles (IDLE, REQ, RESP with immediate response).
- A new grant is possible in the IDLE cycle right after the response, giving back-to-back transactions.
- Under continuous contention, grants alternate IFU/LSU.
- Reset mid-transaction: forces IDLE next cycle. No resp_valid is issued for the aborted access; masters must also be reset.

Test Plan:
- Single IFU read: m0_req_valid, addr=0x80000000; slave ready at once, responds 0x00000413 after 2 cycles -> m0_req_ready in REQ cycle; m0_resp_valid with data 0x00000413, err=0; grant=01 throughout; busy drops the cycle after the response.
- Simultaneous requests after reset: m0 addr 0x80000004, m1 read addr 0x80001000 -> IFU served first; LSU granted in the next IDLE cycle; grants alternate 01,10,01,10 over 4 back-to-back transactions.
- LSU write: addr=0x80002000, wdata=0xDEADBEEF, wmask=0011 -> s_req_wen=1, s_req_wdata=0xDEADBEEF, s_req_wmask=0011 while s_req_ready is held low for 3 cycles (payload stable); m1_resp_valid with data 0.
- Timeout with TIMEOUT=4: slave accepts but never responds -> m1_resp_valid with err=1, data=0 exactly 4 cycles after entering RESP; a slave response 2 cycles later is ignored; FSM is IDLE.
- Reset in RESP: assert rst for one cycle -> next cycle busy=0, grant=00, no resp_valid pulse; a subsequent tie goes to IFU.
- Slave error: s_resp_err=1 with data 0x12345678 on an IFU read -> m0_resp_err=1, m0_resp_data=0x12345678; LSU outputs stay 0.
